// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the tinyalu memory interface and instruction unit.
package tinyalu_pkg;

  localparam int unsigned MEM_ADDR_W = 14;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrLo,
    StWrHi,
    StDone,
    StRelease
  } mem_if_state_t;

endpackage

// File: rtl/mem_ack_timer.sv
// Counts consecutive no-ack cycles of a memory beat; expired flags the last permitted wait cycle.
module mem_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT);

  logic [CntW-1:0] count_q, count_d;

  // expired in the ACK_TIMEOUT-th request cycle, so the abort lands one cycle later
  assign expired = (count_q == CntW'(ACK_TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_interface_unit.sv
// Turns level load/store requests into byte-wide req/ack memory beats with an ack timeout.
module mem_interface_unit
  import tinyalu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned ADDR_W      = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       result,
  output logic [7:0]        data,
  output logic              mem_done,
  output logic              mem_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  mem_if_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       result_q, result_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic timer_clear, timer_en, expired;

  mem_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    result_d    = result_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    maddr_d     = maddr_q;
    wdata_d     = wdata_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // load has priority; a simultaneous store is dropped silently
        if (load) begin
          state_d     = StRd;
          addr_d      = addr;
          result_d    = result;
          req_d       = 1'b1;
          we_d        = 1'b0;
          maddr_d     = addr;
          timer_clear = 1'b1;
        end else if (store) begin
          state_d     = StWrLo;
          addr_d      = addr;
          result_d    = result;
          req_d       = 1'b1;
          we_d        = 1'b1;
          maddr_d     = addr;
          wdata_d     = result[7:0];
          timer_clear = 1'b1;
        end
      end
      StRd: begin
        if (mem_ack) begin
          state_d = StDone;
          data_d  = mem_rdata;
          done_d  = 1'b1;
          req_d   = 1'b0;
        end else if (expired) begin
          state_d = StDone;
          done_d  = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end
      StWrLo: begin
        if (mem_ack) begin
          state_d     = StWrHi;
          maddr_d     = addr_q + ADDR_W'(1);
          wdata_d     = result_q[15:8];
          timer_clear = 1'b1;
        end else if (expired) begin
          state_d = StDone;
          done_d  = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end
      StWrHi: begin
        if (mem_ack || expired) begin
          state_d = StDone;
          done_d  = 1'b1;
          err_d   = !mem_ack;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StRelease;
      end
      StRelease: begin
        // a request level still held from the finished transaction must not retrigger
        if (!load && !store) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      result_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign data      = data_q;
  assign mem_done  = done_q;
  assign mem_err   = err_q;
  assign busy      = busy_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit: transaction-level model, memory responder, per-cycle compare.
module tb_mem_interface_unit;

  localparam int T     = 16;
  localparam int NEVER = 1000;

  logic        clk;
  logic        reset_n;
  logic        load, store;
  logic [13:0] addr;
  logic [15:0] result;
  logic [7:0]  data;
  logic        mem_done, mem_err, busy;
  logic        mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  mem_interface_unit #(
    .ACK_TIMEOUT(T),
    .ADDR_W     (14)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .store     (store),
    .addr      (addr),
    .result    (result),
    .data      (data),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench memory and transaction-level expectations
  logic [7:0]  mem_model [0:16383];
  logic [22:0] exp_q[$];  // {we, addr, wdata}
  int          exp_done_cyc = -1;
  logic        exp_err      = 1'b0;
  int          exp_req_lo   = 1, exp_req_hi  = 0;
  int          exp_busy_lo  = 1, exp_busy_hi = 0;
  logic [7:0]  exp_data     = 8'h00;
  logic [7:0]  pend_data    = 8'h00;
  logic        pend_load    = 1'b0;

  // Responder state
  int          beat_idx = 0, wcnt = 0, cur_w0 = 0, cur_w1 = 0, n_reads = 0;
  int          last_done_cyc = -1;
  logic        last_err = 1'b0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [13:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Responder plus per-cycle compare, all on the falling edge
  initial begin
    int ws;
    logic [22:0] b;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        ws        = (beat_idx == 0) ? cur_w0 : cur_w1;
        mem_ack   = (wcnt == ws);
        mem_rdata = mem_model[mem_addr];
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
      if (prev_req && !prev_ack && mem_req) begin
        check("stable_addr", 32'(mem_addr), 32'(prev_addr));
        check("stable_we", 32'(mem_we), 32'(prev_we));
        check("stable_wdata", 32'(mem_wdata), 32'(prev_wdata));
      end
      if (mem_req && mem_ack) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("beat_we", 32'(mem_we), 32'(b[22]));
          check("beat_addr", 32'(mem_addr), 32'(b[21:8]));
          if (b[22]) check("beat_wdata", 32'(mem_wdata), 32'(b[7:0]));
        end
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else n_reads++;
        beat_idx++;
        wcnt = 0;
      end else if (mem_req) begin
        wcnt++;
      end
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;

      if (mem_done) begin
        last_done_cyc = cyc;
        last_err      = mem_err;
      end
      if (cyc == exp_done_cyc && pend_load) begin
        if (!exp_err) exp_data = pend_data;
        pend_load = 1'b0;
      end
      check("mem_done", 32'(mem_done), 32'(cyc == exp_done_cyc));
      check("mem_err", 32'(mem_err), 32'((cyc == exp_done_cyc) && exp_err));
      check("mem_req", 32'(mem_req), 32'(cyc >= exp_req_lo && cyc <= exp_req_hi));
      check("busy", 32'(busy), 32'(cyc >= exp_busy_lo && cyc <= exp_busy_hi));
      check("data", 32'(data), 32'(exp_data));
    end
  end

  // One request level; w0/w1 are per-beat ack waits (NEVER = no ack), hold = cycles kept after done
  task automatic run_txn(input logic ld, input logic st, input logic [13:0] a,
                         input logic [15:0] r, input int w0, input int w1, input int hold,
                         output int rel);
    int n, d, lat;
    logic err;
    @(negedge clk);
    #2;
    n        = cyc;
    lat      = 0;
    err      = 1'b0;
    beat_idx = 0;
    cur_w0   = w0;
    cur_w1   = w1;
    if (ld) begin
      if (w0 >= NEVER) begin
        err = 1'b1;
        lat = T;
      end else begin
        exp_q.push_back({1'b0, a, 8'h00});
        lat = w0 + 1;
      end
      pend_data = mem_model[a];
      pend_load = 1'b1;
    end else if (st) begin
      if (w0 >= NEVER) begin
        err = 1'b1;
        lat = T;
      end else begin
        exp_q.push_back({1'b1, a, r[7:0]});
        lat = w0 + 1;
        if (w1 >= NEVER) begin
          err = 1'b1;
          lat += T;
        end else begin
          exp_q.push_back({1'b1, a + 14'd1, r[15:8]});
          lat += w1 + 1;
        end
      end
    end
    d             = n + 1 + lat;
    exp_done_cyc  = d;
    exp_err       = err;
    exp_req_lo    = n + 1;
    exp_req_hi    = d - 1;
    exp_busy_lo   = n + 1;
    exp_busy_hi   = (hold > 1) ? d + hold : d + 1;
    last_done_cyc = -1;
    load   = ld;
    store  = st;
    addr   = a;
    result = r;
    while (cyc < d + hold) @(negedge clk);
    #2;
    load  = 1'b0;
    store = 1'b0;
    while (cyc <= exp_busy_hi) @(negedge clk);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("done_err", 32'(last_err), 32'(err));
    rel = (last_done_cyc < 0) ? -1 : last_done_cyc - n;
  endtask

  initial begin
    int rel, n, reads0;
    for (int i = 0; i < 16384; i++) mem_model[i] = 8'h00;
    mem_model[14'h0123] = 8'hA5;
    reset_n = 1'b0;
    load    = 1'b0;
    store   = 1'b0;
    addr    = '0;
    result  = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {data, mem_done, mem_err, busy, mem_req, mem_we, mem_wdata},
          32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait load
    run_txn(1'b1, 1'b0, 14'h0123, 16'h0000, 0, 0, 0, rel);
    check("load_done_cycle", rel, 2);
    check("load_data", 32'(data), 32'hA5);

    // Store with 2-cycle ack latency per beat
    run_txn(1'b0, 1'b1, 14'h0010, 16'hBEEF, 1, 1, 0, rel);
    check("store_done_cycle", rel, 5);
    check("store_lo_byte", 32'(mem_model[14'h0010]), 32'hEF);
    check("store_hi_byte", 32'(mem_model[14'h0011]), 32'hBE);

    // Store at top address wraps high byte to 0
    run_txn(1'b0, 1'b1, 14'h3FFF, 16'h1234, 0, 0, 0, rel);
    check("wrap_done_cycle", rel, 3);
    check("wrap_lo_byte", 32'(mem_model[14'h3FFF]), 32'h34);
    check("wrap_hi_byte", 32'(mem_model[14'h0000]), 32'h12);

    // Load held for 10 cycles after done: one read only
    reads0 = n_reads;
    run_txn(1'b1, 1'b0, 14'h3FFF, 16'h0000, 2, 0, 10, rel);
    check("held_done_cycle", rel, 4);
    check("held_read_count", n_reads - reads0, 1);
    check("held_data", 32'(data), 32'h34);

    // Read timeout keeps previous data
    run_txn(1'b1, 1'b0, 14'h0200, 16'h0000, NEVER, 0, 0, rel);
    check("rd_timeout_cycle", rel, 17);
    check("rd_timeout_data", 32'(data), 32'h34);

    // Store timeout in low beat: no high beat
    run_txn(1'b0, 1'b1, 14'h0300, 16'hCAFE, NEVER, 0, 0, rel);
    check("wr_timeout_cycle", rel, 17);
    check("wr_timeout_lo", 32'(mem_model[14'h0300]), 32'h00);
    check("wr_timeout_hi", 32'(mem_model[14'h0301]), 32'h00);

    // Reset during the high-beat wait
    @(negedge clk);
    #2;
    n            = cyc;
    beat_idx     = 0;
    cur_w0       = 0;
    cur_w1       = NEVER;
    exp_q.push_back({1'b1, 14'h0040, 8'hFE});
    exp_done_cyc = n + 2 + T;
    exp_err      = 1'b1;
    exp_req_lo   = n + 1;
    exp_req_hi   = n + 1 + T;
    exp_busy_lo  = n + 1;
    exp_busy_hi  = n + 3 + T;
    last_done_cyc = -1;
    store  = 1'b1;
    addr   = 14'h0040;
    result = 16'hCAFE;
    while (cyc < n + 4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(mem_done), 32'd0);
    check("rst_mid_beats", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_done_cyc = -1;
    exp_req_lo   = 1;
    exp_req_hi   = 0;
    exp_busy_lo  = 1;
    exp_busy_hi  = 0;
    exp_data     = 8'h00;
    pend_load    = 1'b0;
    store        = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (T + 4) @(negedge clk);
    check("rst_no_done", last_done_cyc, -1);
    check("rst_lo_written", 32'(mem_model[14'h0040]), 32'hFE);
    check("rst_data_cleared", 32'(data), 32'h00);

    // Load and store together: read only
    run_txn(1'b1, 1'b1, 14'h0123, 16'h5A5A, 1, 0, 0, rel);
    check("both_done_cycle", rel, 3);
    check("both_data", 32'(data), 32'hA5);
    check("both_no_write", 32'(mem_model[14'h0124]), 32'h00);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
